lcd_sequencer: RTL
==================

Name: lcd_sequencer

Overview:
- Controller for the 8-bit 8080-style parallel LCD bus (lcd_data, lcd_rs, lcd_wr, lcd_reset, lcd_cs).
- Runs the panel reset pulse, then plays an init script from an external synchronous ROM.
- Afterwards, once per tearing-effect (lcd_fmark) rising edge, issues RAMWR (0x2C) and streams one frame of pixel bytes from a valid/ready source.
- Sits between the board top level and the pixel generator; the top level drives the lcd_reset/lcd_cs open-drain SB_IO enables from the *_inverted outputs.

Parameters:
- ROM_AW, 8, ROM address width.
- WR_LOW, 2, clocks o_lcd_wr is held low per byte (>=1).
- WR_HIGH, 2, clocks o_lcd_wr is held high after each byte (>=1).
- RESET_CYCLES, 120000, clocks the panel reset is asserted.
- RESET_WAIT, 600000, clocks to wait after reset release before the first ROM fetch.
- DELAY_UNIT, 12000, clocks per unit of a ROM delay entry.
- FRAME_BYTES, 153600, pixel bytes per frame (320x240x16bpp).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous reset, active-high
- i_lcd_fmark  in  1  panel tearing-effect pin, asynchronous
- o_lcd_data  out  8  bus data
- o_lcd_rs  out  1  0 = command, 1 = data
- o_lcd_wr  out  1  write strobe; the panel latches on the rising edge
- o_lcd_reset_inverted  out  1  1 = panel reset asserted
- o_lcd_cs_inverted  out  1  1 = chip select asserted
- o_rom_addr  out  ROM_AW  init script address
- i_rom_data  in  10  entry {op[1:0], arg[7:0]}; valid 1 clock after o_rom_addr changes
- i_pix_data  in  8  pixel byte
- i_pix_valid  in  1  pixel byte valid
- o_pix_ready  out  1  pixel byte accepted when valid & ready
- o_init_done  out  1  init script finished (sticky until reset)
- o_frame_start  out  1  one-clock pulse when RAMWR is issued
- o_overrun  out  1  one-clock pulse on an fmark edge that arrives while streaming

Behaviour:
- Reset values:
  - o_lcd_wr=1, o_lcd_rs=0, o_lcd_data=0
  - o_lcd_reset_inverted=1, o_lcd_cs_inverted=0
  - o_rom_addr=0, o_pix_ready=0, o_init_done=0
  - o_frame_start=0, o_overrun=0
  - state=RST_ASSERT, all counters 0
- Reset at any point, including mid-strobe or mid-frame, aborts immediately to these values with no completion of the bus cycle.
- ROM ops:
  - 00 = command byte (rs=0)
  - 01 = data byte (rs=1)
  - 10 = delay of arg*DELAY_UNIT clocks; arg=0 means no delay, proceed next clock
  - 11 = end of script
- States:
  - RST_ASSERT: hold reset for RESET_CYCLES clocks, then deassert reset.
  - RST_WAIT: RESET_WAIT clocks, then set o_lcd_cs_inverted=1.
  - FETCH: present o_rom_addr, wait 1 clock.
  - DECODE: act on i_rom_data.
  - WR_L: drive data/rs, o_lcd_wr=0 for WR_LOW clocks.
  - WR_H: o_lcd_wr=1 for WR_HIGH clocks.
  - DELAY: count down, then FETCH.
  - WAIT_FM: idle.
  - CMD: write 0x2C with rs=0.
  - STREAM: pixel transfer.
- Data and rs are stable for the whole WR_L+WR_H window; they change only on entry to WR_L.
- Each ROM entry advances o_rom_addr by 1 after it is consumed.
- ROM end handling:
  - Op 11 or the last address (2^ROM_AW-1) reached with no 11 ends the script.
  - The entry at the last address is executed first, then the script ends.
  - o_rom_addr does not wrap.
  - o_init_done goes to 1 and the state moves to WAIT_FM.
- fmark: 2-flop synchronizer plus edge detect, giving 3 clocks latency from the pin to detection. In WAIT_FM a rising edge moves to CMD; o_frame_start pulses in the first WR_L clock of the 0x2C write.
- STREAM:
  - o_pix_ready=1 only while the bus is idle in STREAM.
  - On valid&ready: capture the byte, drop ready the next clock, run WR_L/WR_H with rs=1, then raise ready again.
  - Max throughput is 1 byte per (WR_LOW+WR_HIGH+1) clocks.
  - valid low leaves the bus idle with wr=1 indefinitely.
- Byte counter (18 bits): after the byte numbered FRAME_BYTES completes its WR_H phase, clear the counter, drop ready, and return to WAIT_FM.
- An fmark edge during CMD/STREAM pulses o_overrun and is otherwise ignored; it does not restart the frame.
- An fmark edge during init is ignored, with no overrun pulse.
- Simultaneous FRAME_BYTES completion and an fmark edge: the edge counts as overrun; return to WAIT_FM and wait for the next edge.

Test Plan (bench uses RESET_CYCLES=4, RESET_WAIT=6, DELAY_UNIT=3, FRAME_BYTES=4, WR_LOW=WR_HIGH=2):
- Reset release:
  - o_lcd_reset_inverted=1 for 4 clocks, then 0.
  - o_lcd_cs_inverted rises 6 clocks later.
  - o_rom_addr=0 on the first fetch.
- ROM {00_2A, 01_00, 10_02, 10_00, 11_xx}:
  - Two strobes: rs=0/data=0x2A, then rs=1/data=0x00, each with wr low 2 and high 2.
  - Then a 6-clock gap, no gap for the zero delay, o_init_done=1, o_rom_addr=4.
- fmark toggled after init:
  - o_frame_start pulses.
  - data=0x2C with rs=0.
  - o_pix_ready rises after its WR_H.
- Stream source always valid with 0x11, 0x22, 0x33, 0x44:
  - Four rs=1 strobes, 5 clocks apart.
  - Ready drops after the 4th, state returns to waiting.
  - A 5th byte is not accepted.
- Source valid gapped: no strobe while valid=0; byte order preserved.
- Robustness:
  - fmark edge mid-stream: o_overrun pulses once and the frame completes normally.
  - i_reset asserted during WR_L: next clock wr=1, cs_inverted=0, reset_inverted=1, addr=0.

Source files
------------

// File: rtl/lcd_sequencer.sv
// 8080-style parallel LCD bus sequencer: panel reset, ROM-driven init script,
// then one RAMWR plus a frame of streamed pixel bytes per tearing-effect edge.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// RST_ASSERT | panel reset held asserted
// RST_WAIT   | reset released, waiting before the first ROM fetch
// FETCH      | ROM address presented, data arrives next clock
// DECODE     | act on the fetched ROM entry
// WR_L       | write strobe low, data/rs driven
// WR_H       | write strobe high, data/rs held
// DELAY      | script delay entry counting
// WAIT_FM    | idle until a tearing-effect rising edge
// CMD        | launch the RAMWR (0x2C) command byte
// STREAM     | bus idle, ready for the next pixel byte
module lcd_sequencer #(
   parameter int ROM_AW       = 8,
   parameter int WR_LOW       = 2,
   parameter int WR_HIGH      = 2,
   parameter int RESET_CYCLES = 120000,
   parameter int RESET_WAIT   = 600000,
   parameter int DELAY_UNIT   = 12000,
   parameter int FRAME_BYTES  = 153600
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_lcd_fmark,
   output logic [7:0]        o_lcd_data,
   output logic              o_lcd_rs,
   output logic              o_lcd_wr,
   output logic              o_lcd_reset_inverted,
   output logic              o_lcd_cs_inverted,
   output logic [ROM_AW-1:0] o_rom_addr,
   input  logic [9:0]        i_rom_data,
   input  logic [7:0]        i_pix_data,
   input  logic              i_pix_valid,
   output logic              o_pix_ready,
   output logic              o_init_done,
   output logic              o_frame_start,
   output logic              o_overrun
);

   localparam logic [ROM_AW-1:0] ROM_LAST = '1;
   localparam logic [7:0]        RAMWR    = 8'h2C;

   typedef enum logic [3:0] {
      RST_ASSERT, RST_WAIT, FETCH, DECODE, WR_L, WR_H, DELAY, WAIT_FM, CMD, STREAM
   } state_t;

   // Which kind of byte the shared WR_L/WR_H strobe is carrying.
   typedef enum logic [1:0] {CTX_INIT, CTX_CMD, CTX_PIX} ctx_t;

   state_t            state_q, state_d;
   ctx_t              ctx_q, ctx_d;
   logic [31:0]       timer_q, timer_d;
   logic [31:0]       delay_tc_q, delay_tc_d;
   logic [17:0]       pix_cnt_q, pix_cnt_d;
   logic              script_end_q, script_end_d;
   logic [1:0]        fm_sync_q;
   logic              fm_prev_q;
   logic              wr_q, wr_d;
   logic              rs_q, rs_d;
   logic [7:0]        data_q, data_d;
   logic              rst_inv_q, rst_inv_d;
   logic              cs_inv_q, cs_inv_d;
   logic [ROM_AW-1:0] addr_q, addr_d;
   logic              ready_q, ready_d;
   logic              init_done_q, init_done_d;
   logic              frame_start_q, frame_start_d;
   logic              overrun_q, overrun_d;

   logic [31:0]       timer_tc;
   logic              timer_done;
   logic              fm_edge;
   logic              frame_busy;
   logic [1:0]        rom_op;
   logic [7:0]        rom_arg;
   logic              at_last;

   assign rom_op     = i_rom_data[9:8];
   assign rom_arg    = i_rom_data[7:0];
   assign at_last    = (addr_q == ROM_LAST);
   assign fm_edge    = fm_sync_q[1] & ~fm_prev_q;
   assign frame_busy = (state_q == CMD) || (state_q == STREAM) ||
                       (((state_q == WR_L) || (state_q == WR_H)) && (ctx_q != CTX_INIT));
   assign timer_done = (timer_q == timer_tc);

   always_comb begin
      timer_tc = '0;
      unique case (state_q)
         RST_ASSERT: timer_tc = 32'(RESET_CYCLES - 1);
         RST_WAIT:   timer_tc = 32'(RESET_WAIT - 1);
         WR_L:       timer_tc = 32'(WR_LOW - 1);
         WR_H:       timer_tc = 32'(WR_HIGH - 1);
         DELAY:      timer_tc = delay_tc_q;
         default:    timer_tc = '0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      ctx_d         = ctx_q;
      timer_d       = '0;
      delay_tc_d    = delay_tc_q;
      pix_cnt_d     = pix_cnt_q;
      script_end_d  = script_end_q;
      wr_d          = wr_q;
      rs_d          = rs_q;
      data_d        = data_q;
      rst_inv_d     = rst_inv_q;
      cs_inv_d      = cs_inv_q;
      addr_d        = addr_q;
      ready_d       = ready_q;
      init_done_d   = init_done_q;
      frame_start_d = 1'b0;
      overrun_d     = fm_edge & frame_busy;

      unique case (state_q)
         RST_ASSERT: begin
            if (timer_done) begin
               state_d   = RST_WAIT;
               rst_inv_d = 1'b0;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         RST_WAIT: begin
            if (timer_done) begin
               state_d  = FETCH;
               cs_inv_d = 1'b1;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         FETCH: state_d = DECODE;
         DECODE: begin
            if (rom_op == 2'b11) begin
               state_d     = WAIT_FM;
               init_done_d = 1'b1;
            end else begin
               // The last address is executed but never wrapped past.
               if (at_last) script_end_d = 1'b1;
               else         addr_d       = addr_q + 1'b1;
               if (rom_op[1] == 1'b0) begin
                  state_d = WR_L;
                  ctx_d   = CTX_INIT;
                  data_d  = rom_arg;
                  rs_d    = rom_op[0];
                  wr_d    = 1'b0;
               end else if (rom_arg == 8'd0) begin
                  if (at_last) begin
                     state_d     = WAIT_FM;
                     init_done_d = 1'b1;
                  end else begin
                     state_d = FETCH;
                  end
               end else begin
                  state_d    = DELAY;
                  delay_tc_d = 32'(rom_arg) * 32'(DELAY_UNIT) - 32'd1;
               end
            end
         end
         WR_L: begin
            if (timer_done) begin
               state_d = WR_H;
               wr_d    = 1'b1;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         WR_H: begin
            if (!timer_done) begin
               timer_d = timer_q + 32'd1;
            end else begin
               unique case (ctx_q)
                  CTX_INIT: begin
                     if (script_end_q) begin
                        state_d     = WAIT_FM;
                        init_done_d = 1'b1;
                     end else begin
                        state_d = FETCH;
                     end
                  end
                  CTX_CMD: begin
                     state_d = STREAM;
                     ready_d = 1'b1;
                  end
                  default: begin
                     if (pix_cnt_q == 18'(FRAME_BYTES)) begin
                        state_d   = WAIT_FM;
                        pix_cnt_d = '0;
                        ready_d   = 1'b0;
                     end else begin
                        state_d = STREAM;
                        ready_d = 1'b1;
                     end
                  end
               endcase
            end
         end
         DELAY: begin
            if (timer_done) begin
               if (script_end_q) begin
                  state_d     = WAIT_FM;
                  init_done_d = 1'b1;
               end else begin
                  state_d = FETCH;
               end
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         WAIT_FM: begin
            if (fm_edge) state_d = CMD;
         end
         CMD: begin
            state_d       = WR_L;
            ctx_d         = CTX_CMD;
            data_d        = RAMWR;
            rs_d          = 1'b0;
            wr_d          = 1'b0;
            frame_start_d = 1'b1;
         end
         STREAM: begin
            if (i_pix_valid && ready_q) begin
               state_d   = WR_L;
               ctx_d     = CTX_PIX;
               data_d    = i_pix_data;
               rs_d      = 1'b1;
               wr_d      = 1'b0;
               ready_d   = 1'b0;
               pix_cnt_d = pix_cnt_q + 18'd1;
            end
         end
         default: state_d = RST_ASSERT;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q       <= RST_ASSERT;
         ctx_q         <= CTX_INIT;
         timer_q       <= '0;
         delay_tc_q    <= '0;
         pix_cnt_q     <= '0;
         script_end_q  <= 1'b0;
         fm_sync_q     <= '0;
         fm_prev_q     <= 1'b0;
         wr_q          <= 1'b1;
         rs_q          <= 1'b0;
         data_q        <= '0;
         rst_inv_q     <= 1'b1;
         cs_inv_q      <= 1'b0;
         addr_q        <= '0;
         ready_q       <= 1'b0;
         init_done_q   <= 1'b0;
         frame_start_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ctx_q         <= ctx_d;
         timer_q       <= timer_d;
         delay_tc_q    <= delay_tc_d;
         pix_cnt_q     <= pix_cnt_d;
         script_end_q  <= script_end_d;
         fm_sync_q     <= {fm_sync_q[0], i_lcd_fmark};
         fm_prev_q     <= fm_sync_q[1];
         wr_q          <= wr_d;
         rs_q          <= rs_d;
         data_q        <= data_d;
         rst_inv_q     <= rst_inv_d;
         cs_inv_q      <= cs_inv_d;
         addr_q        <= addr_d;
         ready_q       <= ready_d;
         init_done_q   <= init_done_d;
         frame_start_q <= frame_start_d;
         overrun_q     <= overrun_d;
      end
   end

   assign o_lcd_data           = data_q;
   assign o_lcd_rs             = rs_q;
   assign o_lcd_wr             = wr_q;
   assign o_lcd_reset_inverted = rst_inv_q;
   assign o_lcd_cs_inverted    = cs_inv_q;
   assign o_rom_addr           = addr_q;
   assign o_pix_ready          = ready_q;
   assign o_init_done          = init_done_q;
   assign o_frame_start        = frame_start_q;
   assign o_overrun            = overrun_q;

endmodule
